// File: rtl/pattern_detector_pkg.sv
// -----------------------------------------------------------------------------
// pattern_detector_pkg
// Shared definitions for the serial pattern detector:
//   state_e          - detector FSM state encoding (EMPTY / FILLING / ARMED)
//   DEFAULT_PATTERN  - pattern loaded at reset when the top-level parameter
//                      is left at its default
// -----------------------------------------------------------------------------
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,  // no samples collected since last restart
        ST_FILLING = 2'd1,  // some, but fewer than a full pattern of samples
        ST_ARMED   = 2'd2   // history holds a full pattern window
    } state_e;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_detector_saturating_counter.sv
// -----------------------------------------------------------------------------
// saturating_counter
// Event counter that stops at its all-ones value instead of wrapping.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset, count returns to 0
//   inc    - count one event this cycle
//   clr    - zero the count; an inc in the same cycle wins and leaves count=1
//   count  - registered count value
// -----------------------------------------------------------------------------
module saturating_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            // An event coinciding with a clear restarts the count at one.
            if (clr) begin
                count_d = COUNT_ONE;
            end else if (count_q != COUNT_MAX) begin
                count_d = count_q + COUNT_ONE;
            end
        end else if (clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pattern_detector.sv
// -----------------------------------------------------------------------------
// pattern_detector
// Serial bit-pattern detector. Accepted samples shift into a history register
// (new bit at the LSB); when a full window of history equals the stored
// pattern a one-cycle pulse is produced, a sticky flag is set and a
// saturating match counter advances.
// Ports:
//   clk               - clock, rising edge
//   reset             - synchronous active-high reset, highest priority
//   update            - value is a valid sample this cycle
//   value             - serial input bit
//   load              - store pattern_in, flush history (beats update)
//   pattern_in        - new pattern, MSB compared against the oldest bit
//   overlap           - 1: keep history after a match, 0: restart after match
//   clear             - zero match_count and sequence_seen (a match wins)
//   sequence_detected - registered one-cycle pulse per match
//   sequence_seen     - sticky "a match has happened" flag
//   match_count       - saturating number of matches
// -----------------------------------------------------------------------------
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int                       PATTERN_WIDTH = 4,
    parameter int                       COUNT_WIDTH   = 8,
    parameter logic [PATTERN_WIDTH-1:0] RESET_PATTERN = PATTERN_WIDTH'(DEFAULT_PATTERN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     update,
    input  logic                     value,
    input  logic                     load,
    input  logic [PATTERN_WIDTH-1:0] pattern_in,
    input  logic                     overlap,
    input  logic                     clear,
    output logic                     sequence_detected,
    output logic                     sequence_seen,
    output logic [COUNT_WIDTH-1:0]   match_count
);

    localparam int                FILL_W    = $clog2(PATTERN_WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_WIDTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    state_e                   state_q;
    state_e                   state_d;
    logic [PATTERN_WIDTH-1:0] history_q;
    logic [PATTERN_WIDTH-1:0] history_d;
    logic [PATTERN_WIDTH-1:0] pattern_q;
    logic [PATTERN_WIDTH-1:0] pattern_d;
    logic [FILL_W-1:0]        fill_q;
    logic [FILL_W-1:0]        fill_d;
    logic                     detected_q;
    logic                     seen_q;
    logic                     seen_d;

    logic [PATTERN_WIDTH-1:0] hist_shift;
    logic [FILL_W-1:0]        fill_inc;
    logic                     accept;
    logic                     full_after;
    logic                     match;
    logic                     restart;

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            if (restart) begin
                state_d = ST_EMPTY;
            end else if (full_after) begin
                state_d = ST_ARMED;
            end else begin
                state_d = ST_FILLING;
            end
        end
    end

    // ---- FSM: outputs (sample acceptance and match decode) ----
    always_comb begin
        // load discards any sample presented in the same cycle.
        accept     = update && !load;
        hist_shift = {history_q[PATTERN_WIDTH-2:0], value};
        fill_inc   = (state_q == ST_ARMED) ? FILL_FULL : fill_q + FILL_ONE;
        // The window is full after this sample if it already was, or if this
        // sample is the last one missing.
        full_after = (state_q == ST_ARMED) || (fill_q == FILL_LAST);
        match      = accept && full_after && (hist_shift == pattern_q);
        restart    = match && !overlap;
    end

    // ---- History, fill, pattern and sticky flag next values ----
    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        if (load) begin
            pattern_d = pattern_in;
            history_d = '0;
            fill_d    = '0;
        end else if (accept) begin
            if (restart) begin
                history_d = '0;
                fill_d    = '0;
            end else begin
                history_d = hist_shift;
                fill_d    = fill_inc;
            end
        end

        seen_d = seen_q;
        if (match) begin
            seen_d = 1'b1;
        end else if (clear) begin
            seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            history_q  <= '0;
            fill_q     <= '0;
            pattern_q  <= RESET_PATTERN;
            detected_q <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            history_q  <= history_d;
            fill_q     <= fill_d;
            pattern_q  <= pattern_d;
            detected_q <= match;
            seen_q     <= seen_d;
        end
    end

    saturating_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_match_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (clear),
        .count (match_count)
    );

    assign sequence_detected = detected_q;
    assign sequence_seen     = seen_q;

endmodule
